// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: rotates active-low column strobes, debounces press and
// release with one shared down-counter, and emits one valid/ready key event per press.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CYC = 20,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    typedef enum logic [2:0] {
        SETTLE,
        SAMPLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LOAD = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic [3:0]       row_sync_p0;
    logic [3:0]       row_sync_p1;
    logic [3:0]       row_act;
    logic             row_hit;
    logic             fire;

    // Several rows low on one column resolve to the lowest row index.
    function automatic logic [1:0] lowest_row(input logic [3:0] act);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (act[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    assign row_act = ~row_sync_p1;
    assign row_hit = row_act[row_idx];
    assign fire    = (state == DEBOUNCE) && row_hit && (cnt == '0);

    // Stage p0/p1: two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_sync_p0 <= 4'hF;
            row_sync_p1 <= 4'hF;
        end else begin
            row_sync_p0 <= row_n;
            row_sync_p1 <= row_sync_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SETTLE;
            cnt       <= SETTLE_LOAD;
            col_idx   <= 2'd0;
            col_n     <= 4'b1110;
            row_idx   <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                SAMPLE: begin
                    if (row_act == 4'h0) begin
                        col_idx <= col_idx + 2'd1;
                        col_n   <= col_strobe(col_idx + 2'd1);
                        state   <= SETTLE;
                        cnt     <= SETTLE_LOAD;
                    end else begin
                        row_idx <= lowest_row(row_act);
                        state   <= DEBOUNCE;
                        cnt     <= DEBOUNCE_LOAD;
                    end
                end
                DEBOUNCE: begin
                    // A bounce back to inactive restarts the scan on the same column.
                    if (!row_hit) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end else if (cnt == '0) begin
                        state    <= HELD;
                        key_held <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        state <= RELEASE;
                        cnt   <= DEBOUNCE_LOAD;
                    end
                end
                RELEASE: begin
                    if (row_hit) begin
                        state <= HELD;
                    end else if (cnt == '0) begin
                        key_held <= 1'b0;
                        col_idx  <= col_idx + 2'd1;
                        col_n    <= col_strobe(col_idx + 2'd1);
                        state    <= SETTLE;
                        cnt      <= SETTLE_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= SETTLE_LOAD;
                end
            endcase

            // A fresh event may replace one being accepted this same cycle.
            if (fire) begin
                if (!key_valid || key_ready) begin
                    key_code  <= {row_idx, col_idx};
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

    a_col_one_cold: assert property (@(posedge clk) $onehot(~col_n));

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed scenarios plus randomized presses, with a
// procedural reference model of the scan/debounce/handshake rules checked every cycle.
module tb_keypad_scan_ctrl;

    localparam int SETTLE_CYC   = 2;
    localparam int DEBOUNCE_CYC = 4;
    localparam int CNT_W        = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_n = 4'hF;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       key_held;
    logic       overflow;

    keypad_scan_ctrl #(
        .SETTLE_CYC  (SETTLE_CYC),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          n_rise   = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] pressed = 16'h0;   // bit r*4+c = key (row r, col c) held down

    int         exp_col;
    logic [3:0] exp_code;
    logic       exp_valid;
    logic       exp_held;
    logic       exp_ovf;
    logic [3:0] hist[$];            // row_n seen at the previous two clock edges

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] strobe(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    function automatic logic [3:0] keypad_rows(input logic [3:0] cols, input logic [15:0] keys);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (keys[ri*4+ci] && !cols[ci]) r[ri] = 1'b0;
        return r;
    endfunction

    function automatic int lowest(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (a[i]) return i;
        return 0;
    endfunction

    // Keypad emulation: a pressed key pulls its row low while its column is strobed.
    initial forever begin
        @(negedge clk);
        #1;
        row_n = keypad_rows(col_n, pressed);
    end

    // ---------------- reference model ----------------
    task automatic step(output logic [3:0] act, output logic rdy, output bit ok);
        @(posedge clk or posedge rst);
        ok  = !rst;
        act = ~hist[0];
        rdy = key_ready;
        if (ok) begin
            hist.push_back(row_n);
            void'(hist.pop_front());
        end
    endtask

    task automatic handshake(input bit fire, input logic [3:0] code, input logic rdy);
        if (fire) begin
            if (!exp_valid || rdy) begin
                exp_code  = code;
                exp_valid = 1'b1;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic run_scan();
        logic [3:0] act;
        logic       rdy;
        bit         ok;
        bit         aborted;
        int         col = 0;
        int         r;
        int         quiet;
        forever begin
            exp_col = col;
            for (int i = 0; i < SETTLE_CYC + 1; i++) begin
                step(act, rdy, ok);
                if (!ok) return;
                handshake(1'b0, 4'h0, rdy);
            end
            if (act == 4'h0) begin
                col = (col + 1) % 4;
                continue;
            end
            r = lowest(act);
            aborted = 1'b0;
            for (int i = 0; i < DEBOUNCE_CYC; i++) begin
                step(act, rdy, ok);
                if (!ok) return;
                if (!act[r]) begin
                    handshake(1'b0, 4'h0, rdy);
                    aborted = 1'b1;
                    break;
                end
                if (i == DEBOUNCE_CYC - 1) begin
                    handshake(1'b1, 4'(r * 4 + col), rdy);
                    exp_held = 1'b1;
                end else begin
                    handshake(1'b0, 4'h0, rdy);
                end
            end
            if (aborted) continue;
            // Release completes after DEBOUNCE_CYC+1 consecutive inactive samples.
            quiet = 0;
            while (quiet < DEBOUNCE_CYC + 1) begin
                step(act, rdy, ok);
                if (!ok) return;
                handshake(1'b0, 4'h0, rdy);
                quiet = act[r] ? 0 : quiet + 1;
            end
            exp_held = 1'b0;
            col = (col + 1) % 4;
        end
    endtask

    initial forever begin
        exp_col   = 0;
        exp_code  = 4'h0;
        exp_valid = 1'b0;
        exp_held  = 1'b0;
        exp_ovf   = 1'b0;
        hist.delete();
        hist.push_back(4'hF);
        hist.push_back(4'hF);
        wait (!rst);
        run_scan();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("col_n", col_n, strobe(exp_col));
        check("col_one_cold", {3'b000, ($countones(col_n) == 3)}, 4'h1);
        check("key_code", key_code, exp_code);
        check("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
        check("key_held", {3'b000, key_held}, {3'b000, exp_held});
        check("overflow", {3'b000, overflow}, {3'b000, exp_ovf});
        if (key_valid && !prev_valid) n_rise++;
        prev_valid = key_valid;
    end

    // sel: 0 = key_held, 1 = key_valid, 2 = col_n
    task automatic wait_for(input string name, input int sel, input logic [3:0] val, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = (key_held == val[0]);
                1:       hit = (key_valid == val[0]);
                default: hit = (col_n == val);
            endcase
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s timeout actual=never required=%b t=%0t", name, val, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_n"}, col_n, 4'b1110);
        check({tag, "_code"}, key_code, 4'h0);
        check({tag, "_valid"}, {3'b000, key_valid}, 4'h0);
        check({tag, "_held"}, {3'b000, key_held}, 4'h0);
        check({tag, "_ovf"}, {3'b000, overflow}, 4'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          base;
        int          left;
        int          k0;
        int          k1;
        logic [15:0] keys;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle scan: each column held SETTLE_CYC+1 = 3 cycles.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("idle_col", col_n, strobe(((k + 1) / 3) % 4));
            check("idle_valid", {3'b000, key_valid}, 4'h0);
        end

        // Clean press of row 2 / col 1.
        base = n_rise;
        pressed[2*4+1] = 1'b1;
        wait_for("t2_valid", 1, 4'h1, 80);
        check("t2_code", key_code, 4'b1001);
        check("t2_held", {3'b000, key_held}, 4'h1);
        key_ready = 1'b1;
        @(negedge clk);
        check("t2_clear", {3'b000, key_valid}, 4'h0);
        key_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("t2_still_held", {3'b000, key_held}, 4'h1);
        pressed = 16'h0;
        wait_for("t2_release", 0, 4'h0, 40);
        check("t2_resume_col", col_n, 4'b1011);
        check_int("t2_events", n_rise - base, 1);

        // Bounce on row 0 / col 3: low 2, high 1, then steady.
        wait_for("t3_col3", 2, 4'b0111, 20);
        base = n_rise;
        pressed[3] = 1'b1;
        repeat (2) @(negedge clk);
        pressed[3] = 1'b0;
        @(negedge clk);
        pressed[3] = 1'b1;
        wait_for("t3_valid", 1, 4'h1, 40);
        check("t3_code", key_code, 4'b0011);
        check_int("t3_events", n_rise - base, 1);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;

        // Release glitch while held.
        repeat (4) @(negedge clk);
        base = n_rise;
        pressed[3] = 1'b0;
        repeat (2) @(negedge clk);
        pressed[3] = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_held", {3'b000, key_held}, 4'h1);
        check_int("t4_no_event", n_rise - base, 0);
        pressed = 16'h0;
        wait_for("t4_release", 0, 4'h0, 40);
        check("t4_wrap_col", col_n, 4'b1110);

        // Overflow: second event while the first is still pending.
        pressed[1*4+0] = 1'b1;
        wait_for("t5_held1", 0, 4'h1, 80);
        check("t5_code1", key_code, 4'b0100);
        check("t5_valid1", {3'b000, key_valid}, 4'h1);
        pressed = 16'h0;
        wait_for("t5_rel1", 0, 4'h0, 40);
        pressed[3*4+3] = 1'b1;
        wait_for("t5_held2", 0, 4'h1, 80);
        pressed = 16'h0;
        wait_for("t5_rel2", 0, 4'h0, 40);
        check("t5_code_kept", key_code, 4'b0100);
        check("t5_valid_kept", {3'b000, key_valid}, 4'h1);
        check("t5_overflow", {3'b000, overflow}, 4'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        rst = 1'b0;

        // Multi-row resolves to lowest row; then async reset mid-debounce.
        pressed = 16'h1010;
        wait_for("t6_valid", 1, 4'h1, 80);
        check("t6_code", key_code, 4'b0100);
        pressed = 16'h0;
        wait_for("t6_rel", 0, 4'h0, 40);
        wait_for("t6_col2", 2, 4'b1011, 30);
        pressed[2*4+2] = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_pending", {3'b000, key_valid}, 4'h1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        pressed = 16'h0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized presses, bounces, ready and occasional async reset.
        left = 0;
        keys = 16'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            key_ready = ($urandom_range(0, 2) != 0);
            if (left == 0) begin
                k0 = int'($urandom_range(0, 15));
                k1 = int'($urandom_range(0, 15));
                keys = 16'h0;
                case ($urandom_range(0, 3))
                    0:       keys = 16'h0;
                    1, 2:    keys[k0] = 1'b1;
                    default: begin
                        keys[k0] = 1'b1;
                        keys[k1] = 1'b1;
                    end
                endcase
                left = int'($urandom_range(1, 30));
            end else begin
                left--;
            end
            pressed = ($urandom_range(0, 9) == 0) ? 16'h0 : keys;
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
